// File: rtl/exec_muldiv_fwd_if.sv
// Issue/forwarding/result bundle between the EX stage and the iterative mul/div unit.
interface exec_muldiv_fwd_if #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
);
  logic                in_valid;
  logic [2:0]          op;
  logic                kill;
  logic [REG_BITS-1:0] rs_num;
  logic [REG_BITS-1:0] rt_num;
  logic [WIDTH-1:0]    rs_data;
  logic [WIDTH-1:0]    rt_data;
  logic                exmem_wr_en;
  logic                memwb_wr_en;
  logic [REG_BITS-1:0] exmem_dst;
  logic [REG_BITS-1:0] memwb_dst;
  logic [WIDTH-1:0]    exmem_data;
  logic [WIDTH-1:0]    memwb_data;
  logic                stall;
  logic [WIDTH-1:0]    result;
  logic                result_valid;
  logic                div_by_zero;

  modport master (
    output in_valid, op, kill, rs_num, rt_num, rs_data, rt_data,
           exmem_wr_en, memwb_wr_en, exmem_dst, memwb_dst, exmem_data, memwb_data,
    input  stall, result, result_valid, div_by_zero
  );

  modport slave (
    input  in_valid, op, kill, rs_num, rt_num, rs_data, rt_data,
           exmem_wr_en, memwb_wr_en, exmem_dst, memwb_dst, exmem_data, memwb_data,
    output stall, result, result_valid, div_by_zero
  );
endinterface

// File: rtl/exec_muldiv_fwd.sv
// Iterative radix-2 multiply/divide beside the EX-stage ALU, with operand forwarding at issue.
// Optional two's-complement operation (op[2]) is enabled by defining SIGNED_MULDIV_EN.
module exec_muldiv_fwd #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 5
) (
  input logic              clk,
  input logic              rst,
  exec_muldiv_fwd_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_BITS-1:0]   cnt;
  logic [WIDTH-1:0]      hi, lo, dvs;
  logic [1:0]            op_q;
  logic                  neg_res, neg_rem;
  logic [WIDTH-1:0]      result_q;
  logic                  dz_q;

  logic [WIDTH-1:0]      fwd_a, fwd_b, mag_a, mag_b;
  logic                  sgn_op, neg_a, neg_b;
  logic                  issue, last;

  logic [WIDTH:0]        sum, shl;
  logic [WIDTH-1:0]      diff, hi_nxt, lo_nxt, fin;
  logic [2*WIDTH-1:0]    prod, prod_s;
  logic                  ge;

  always_comb begin
    fwd_a = bus.rs_data;
    if (bus.exmem_wr_en && bus.exmem_dst == bus.rs_num)      fwd_a = bus.exmem_data;
    else if (bus.memwb_wr_en && bus.memwb_dst == bus.rs_num) fwd_a = bus.memwb_data;
  end

  always_comb begin
    fwd_b = bus.rt_data;
    if (bus.exmem_wr_en && bus.exmem_dst == bus.rt_num)      fwd_b = bus.exmem_data;
    else if (bus.memwb_wr_en && bus.memwb_dst == bus.rt_num) fwd_b = bus.memwb_data;
  end

`ifdef SIGNED_MULDIV_EN
  assign sgn_op = bus.op[2];
`else
  logic unused_op2;
  assign unused_op2 = bus.op[2];
  assign sgn_op     = 1'b0;
`endif

  // Datapath always works on magnitudes; signs are reapplied when the result is formed.
  assign neg_a = sgn_op & fwd_a[WIDTH-1];
  assign neg_b = sgn_op & fwd_b[WIDTH-1];
  assign mag_a = neg_a ? ('0 - fwd_a) : fwd_a;
  assign mag_b = neg_b ? ('0 - fwd_b) : fwd_b;

  assign issue = bus.in_valid & ~bus.kill;
  assign last  = (cnt == CNT_BITS'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.stall        = 1'b0;
    bus.result_valid = 1'b0;
    bus.div_by_zero  = 1'b0;
    case (state)
      IDLE:    if (issue) state_nxt = RUN;
      RUN:     if (bus.kill) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    bus.stall        = bus.in_valid & (state != DONE) & ~bus.kill;
    bus.result_valid = (state == DONE) & ~bus.kill;
    bus.div_by_zero  = bus.result_valid & dz_q;
  end

  // Shift-add multiply: {hi,lo} holds partial product with multiplier in lo.
  // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    shl  = {hi, lo[WIDTH-1]};
    ge   = (shl >= {1'b0, dvs});
    diff = shl[WIDTH-1:0] - dvs;
    if (op_q[1]) begin
      hi_nxt = ge ? diff : shl[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ge};
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = {hi_nxt, lo_nxt};
    prod_s = neg_res ? ('0 - prod) : prod;
    case (op_q)
      2'b00:   fin = prod_s[WIDTH-1:0];
      2'b01:   fin = prod_s[2*WIDTH-1:WIDTH];
      2'b10:   fin = (dvs == '0) ? '1 : (neg_res ? ('0 - lo_nxt) : lo_nxt);
      default: fin = neg_rem ? ('0 - hi_nxt) : hi_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      dvs      <= '0;
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          cnt     <= '0;
          hi      <= '0;
          lo      <= mag_a;
          dvs     <= mag_b;
          op_q    <= bus.op[1:0];
          neg_res <= neg_a ^ neg_b;
          neg_rem <= neg_a;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          if (last && !bus.kill) begin
            result_q <= fin;
            dz_q     <= op_q[1] & (dvs == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_exec_muldiv_fwd.sv
// Randomised and directed bench for exec_muldiv_fwd against a plain-arithmetic reference model.
module tb_exec_muldiv_fwd;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  exec_muldiv_fwd_if #(.WIDTH(W), .REG_BITS(3)) bus ();

  exec_muldiv_fwd #(.WIDTH(W), .REG_BITS(3), .CNT_BITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fwd_ref(input logic [2:0] num, input logic [15:0] rf,
                                          input logic ex_en, input logic [2:0] ex_dst, input logic [15:0] ex_d,
                                          input logic wb_en, input logic [2:0] wb_dst, input logic [15:0] wb_d);
    if (ex_en && ex_dst == num) return ex_d;
    if (wb_en && wb_dst == num) return wb_d;
    return rf;
  endfunction

  task automatic model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic dz);
    logic        sg;
    int          sa, sb;
    logic [31:0] p;
`ifdef SIGNED_MULDIV_EN
    sg = o[2];
`else
    sg = 1'b0;
`endif
    sa = sg ? int'($signed(a)) : int'(a);
    sb = sg ? int'($signed(b)) : int'(b);
    p  = sg ? 32'(sa * sb) : 32'(a) * 32'(b);
    dz = o[1] && (b == 16'h0);
    case (o[1:0])
      2'b00:   r = p[15:0];
      2'b01:   r = p[31:16];
      2'b10:   r = (b == 16'h0) ? 16'hFFFF : 16'(sa / sb);
      default: r = (b == 16'h0) ? a : 16'(sa % sb);
    endcase
  endtask

  task automatic fwd_off();
    bus.rs_num = 3'd0; bus.rt_num = 3'd1;
    bus.exmem_wr_en = 1'b0; bus.memwb_wr_en = 1'b0;
    bus.exmem_dst = 3'd0; bus.memwb_dst = 3'd0;
    bus.exmem_data = 16'h0; bus.memwb_data = 16'h0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic edz, input string nm, input bit hold);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
    #1;
    total++;
    if (bus.stall !== 1'b1 || bus.result_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s issue: stall=%b valid=%b, want stall=1 valid=0", nm, bus.stall, bus.result_valid);
    end
    for (int k = 1; k <= W; k++) begin
      @(negedge clk); #1;
      total++;
      if (bus.stall !== 1'b1 || bus.result_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s run%0d: stall=%b valid=%b, want stall=1 valid=0", nm, k, bus.stall, bus.result_valid);
      end
    end
    @(negedge clk); #1;
    total++;
    if (bus.result_valid !== 1'b1 || bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL %s done: valid=%b stall=%b, want valid=1 stall=0", nm, bus.result_valid, bus.stall);
    end
    total++;
    if (bus.result !== er || bus.div_by_zero !== edz) begin
      bad++;
      $display("FAIL %s result: got %h dz=%b, want %h dz=%b", nm, bus.result, bus.div_by_zero, er, edz);
    end
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic quiet_cycles(input int n, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      if (bus.result_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL %s: result_valid seen=1, want 0", nm);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.op = 3'b000; bus.kill = 1'b0;
    bus.rs_data = 16'h0; bus.rt_data = 16'h0;
    fwd_off();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.result !== 16'h0 || bus.result_valid !== 1'b0 || bus.div_by_zero !== 1'b0 || bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL reset: result=%h valid=%b dz=%b stall=%b, want 0 0 0 0",
               bus.result, bus.result_valid, bus.div_by_zero, bus.stall);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_arith();
    do_op(3'b000, 16'h0123, 16'h0010, 16'h1230, 1'b0, "mul_basic", 1'b0);
    do_op(3'b001, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, "mulh_ffff", 1'b0);
    do_op(3'b000, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, "mul_ffff", 1'b0);
    do_op(3'b010, 16'd100, 16'd7, 16'h000E, 1'b0, "div_100_7", 1'b0);
    do_op(3'b011, 16'd100, 16'd7, 16'h0002, 1'b0, "rem_100_7", 1'b0);
    do_op(3'b010, 16'd5, 16'd0, 16'hFFFF, 1'b1, "div_by0", 1'b0);
    do_op(3'b011, 16'd5, 16'd0, 16'h0005, 1'b1, "rem_by0", 1'b0);
  endtask

  task automatic test_forwarding();
    bus.rs_num = 3'd3; bus.rt_num = 3'd1;
    bus.exmem_wr_en = 1'b1; bus.exmem_dst = 3'd3; bus.exmem_data = 16'h0004;
    bus.memwb_wr_en = 1'b1; bus.memwb_dst = 3'd3; bus.memwb_data = 16'h0009;
    do_op(3'b000, 16'h0077, 16'h0003, 16'h000C, 1'b0, "fwd_exmem", 1'b0);
    bus.exmem_wr_en = 1'b0;
    do_op(3'b000, 16'h0077, 16'h0003, 16'h001B, 1'b0, "fwd_memwb", 1'b0);
    bus.rs_num = 3'd0; bus.rt_num = 3'd7; bus.memwb_dst = 3'd7; bus.memwb_data = 16'h0010;
    do_op(3'b000, 16'h0005, 16'h0003, 16'h0050, 1'b0, "fwd_rt_r7", 1'b0);
    fwd_off();
  endtask

  task automatic test_kill();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.rs_data = 16'h1234; bus.rt_data = 16'h0003;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    bus.kill = 1'b1;
    #1;
    total++;
    if (bus.stall !== 1'b0 || bus.result_valid !== 1'b0) begin
      bad++;
      $display("FAIL kill_run: stall=%b valid=%b, want 0 0", bus.stall, bus.result_valid);
    end
    @(negedge clk); bus.kill = 1'b0; bus.in_valid = 1'b0;
    quiet_cycles(W + 3, "kill_run_quiet");
    do_op(3'b000, 16'h0123, 16'h0010, 16'h1230, 1'b0, "after_kill", 1'b0);

    // kill on the edge that would enter DONE
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'b010; bus.rs_data = 16'd9; bus.rt_data = 16'd0;
    for (int k = 1; k <= W; k++) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk); bus.kill = 1'b0; bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.result_valid !== 1'b0 || bus.result !== 16'h1230 || bus.div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL kill_done_edge: valid=%b result=%h dz=%b, want 0 1230 0",
               bus.result_valid, bus.result, bus.div_by_zero);
    end

    // kill while in DONE
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'b010; bus.rs_data = 16'd9; bus.rt_data = 16'd0;
    for (int k = 1; k <= W + 1; k++) @(negedge clk);
    bus.kill = 1'b1;
    #1;
    total++;
    if (bus.result_valid !== 1'b0 || bus.stall !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL kill_in_done: valid=%b stall=%b dz=%b, want 0 0 0",
               bus.result_valid, bus.stall, bus.div_by_zero);
    end
    @(negedge clk); bus.kill = 1'b0; bus.in_valid = 1'b0;

    // kill in IDLE blocks the issue
    @(negedge clk); bus.in_valid = 1'b1; bus.kill = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0; bus.kill = 1'b0;
    quiet_cycles(W + 3, "kill_idle_quiet");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.rs_data = 16'h0101; bus.rt_data = 16'h0007;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.result !== 16'h0 || bus.result_valid !== 1'b0 || bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: result=%h valid=%b stall=%b, want 0 0 0",
               bus.result, bus.result_valid, bus.stall);
    end
    @(negedge clk); rst = 1'b0;
    quiet_cycles(W + 3, "reset_mid_run_quiet");
    do_op(3'b000, 16'h0101, 16'h0007, 16'h0707, 1'b0, "after_reset", 1'b0);
  endtask

  task automatic test_signed();
`ifdef SIGNED_MULDIV_EN
    do_op(3'b110, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, "sdiv_m7_2", 1'b0);
    do_op(3'b111, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, "srem_m7_2", 1'b0);
    do_op(3'b110, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, "sdiv_min_m1", 1'b0);
    do_op(3'b111, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, "srem_min_m1", 1'b0);
    do_op(3'b110, 16'hFFF9, 16'h0000, 16'hFFFF, 1'b1, "sdiv_by0", 1'b0);
    do_op(3'b111, 16'hFFF9, 16'h0000, 16'hFFF9, 1'b1, "srem_by0", 1'b0);
    do_op(3'b101, 16'hFFFD, 16'h0005, 16'hFFFF, 1'b0, "smulh", 1'b0);
`else
    do_op(3'b110, 16'hFFF9, 16'h0002, 16'h7FFC, 1'b0, "op2_ignored_div", 1'b0);
    do_op(3'b111, 16'hFFF9, 16'h0002, 16'h0001, 1'b0, "op2_ignored_rem", 1'b0);
    do_op(3'b101, 16'hFFFD, 16'h0005, 16'h0004, 1'b0, "op2_ignored_mulh", 1'b0);
`endif
    do_op(3'b100, 16'hFFFD, 16'h0005, 16'hFFF1, 1'b0, "op2_mul_low", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] er;
    logic        edz;
    model(3'b010, 16'd1000, 16'd33, er, edz);
    do_op(3'b010, 16'd1000, 16'd33, er, edz, "b2b_0", 1'b1);
    model(3'b001, 16'hBEEF, 16'h1234, er, edz);
    do_op(3'b001, 16'hBEEF, 16'h1234, er, edz, "b2b_1", 1'b1);
    model(3'b011, 16'hBEEF, 16'h0101, er, edz);
    do_op(3'b011, 16'hBEEF, 16'h0101, er, edz, "b2b_2", 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [15:0] a, b, fa, fb, er;
    logic        edz;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'h0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      bus.rs_num      = 3'($urandom_range(0, 7));
      bus.rt_num      = 3'($urandom_range(0, 7));
      bus.exmem_wr_en = 1'($urandom_range(0, 1));
      bus.memwb_wr_en = 1'($urandom_range(0, 1));
      bus.exmem_dst   = 3'($urandom_range(0, 7));
      bus.memwb_dst   = 3'($urandom_range(0, 7));
      bus.exmem_data  = 16'($urandom);
      bus.memwb_data  = 16'($urandom);
      fa = fwd_ref(bus.rs_num, a, bus.exmem_wr_en, bus.exmem_dst, bus.exmem_data,
                   bus.memwb_wr_en, bus.memwb_dst, bus.memwb_data);
      fb = fwd_ref(bus.rt_num, b, bus.exmem_wr_en, bus.exmem_dst, bus.exmem_data,
                   bus.memwb_wr_en, bus.memwb_dst, bus.memwb_data);
      model(o, fa, fb, er, edz);
      do_op(o, a, b, er, edz, $sformatf("rand%0d_op%0d", i, o), (i % 3) == 0);
    end
    bus.in_valid = 1'b0;
    fwd_off();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_forwarding();
    test_kill();
    test_reset_mid_run();
    test_signed();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
